shared_adder_arbiter: RTL and testbench
=======================================

# shared_adder_arbiter

Round-robin arbiter and two-stage pipeline that time-shares one `carry_select_adder_20bit` instance between `NREQ` requesters in the ODE solver datapath.
- Each requester issues a 20-bit add or subtract with a valid/ready handshake.
- Results return in grant order, tagged with the requester index, with carry and signed-overflow flags.
- The block replaces per-stage adders in the integrator loop, so only one physical adder is built.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8)
- `IDW`, 2: width of the requester id, equal to clog2(NREQ)

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  NREQ  per-requester operation valid
- `req_ready`  out  NREQ  one-hot grant, at most one bit high per cycle
- `req_sub`  in  NREQ  1 = A−B, 0 = A+B
- `req_a`  in  NREQ*20  operand A, requester i at bits [20i+19:20i]
- `req_b`  in  NREQ*20  operand B, same packing as `req_a`
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  IDW  index of the originating requester
- `rsp_sum`  out  20  result
- `rsp_cout`  out  1  adder carry out
- `rsp_v`  out  1  two's-complement overflow

## Operation
- **Stage S1 (operand register):** holds a, b, sub and id of the granted request, plus `s1_full`.
- **Stage S2 (result register):** holds sum, cout, v and id, plus `s2_full`. `rsp_valid` = `s2_full`.
- **Adder:** combinational between S1 and S2, fed as in0=S1.a, in1=S1.b, sub=S1.sub, cin=0. Subtract therefore computes A + ~B + 1.
- **Advance conditions:**
  - `s2_adv` = `s1_full` & (!`s2_full` | `rsp_ready`)
  - `s1_free` = !`s1_full` | `s2_adv`
- **Arbitration:**
  - Evaluated only when `s1_free`.
  - Winner is the first i with `req_valid[i]`=1, scanning from (`last`+1) mod NREQ upward with wrap.
  - `req_ready[winner]`=1; all other ready bits are 0.
  - Handshake fires when valid & ready. The operands load into S1 and `last` updates to the winner.
  - When `s1_free`=0, all ready bits are 0 and `last` is held.
- **req_ready path:** combinational from `req_valid`, `s1_full`, `s2_full` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- **Requester obligations:** once asserted, `req_valid` and the operands stay stable until the handshake fires.
- **Control FSM** (derived from the full bits):
  - EMPTY (neither stage full), FILL (S1 only), FULL (both), DRAIN (S2 only).
  - Simultaneous grant, advance and drain is legal in FULL. All three registers update in the same cycle, so throughput is one op per cycle.
- **Stall:** `rsp_valid`=1 with `rsp_ready`=0 holds S2. S1 holds if full, and grants stop.
- **Reset (any cycle, including mid-operation):**
  - Both full bits clear, `last` = NREQ−1 so requester 0 wins first, and all data registers clear to 0.
  - In-flight operations are discarded without a response.
- **Flag rules:**
  - `rsp_v` = (a19 = b'19) & (sum19 ≠ a19), where b' is the inverted B when subtracting.
  - `rsp_cout` is the raw adder carry: 1 on subtract means no borrow.

## Timing
- **Reset values:** `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_v`=0. `req_ready`=0 during the reset cycle.
- **Latency:** a handshake in cycle N gives `rsp_valid`=1 in cycle N+2 when unstalled.
- **Throughput:** 1 op/cycle sustained while `rsp_ready`=1.
- **Fairness:** each continuously-valid requester is granted within NREQ grants.
- **Critical path:** the adder path S1→S2 is the critical path. No logic follows S2 except saturation, when enabled.

## Configuration
- `ADDER_SAT_EN` defined: on `rsp_v`=1, `rsp_sum` saturates to 0x7FFFF if a19=0, else 0x80000. `rsp_v` still reports the overflow.
- `ADDER_SAT_EN` undefined: `rsp_sum` is the raw wrapped adder sum.

## Structure
- **Shared package `ode_pkg`:**
  - `DATA_W`=20 and `ADD_OP`=0 / `SUB_OP`=1 constants.
  - Saturation limits `SAT_MAX`=20'h7FFFF and `SAT_MIN`=20'h80000.
  - A typedef for the S2 result record (sum, cout, v, id).
- **Sub-module `rr_picker`:** combinational; inputs `req_valid`, `last` and `enable`; outputs the one-hot grant and the encoded id. Reused by other shared-resource arbiters in the solver.
- **Adder:** one `carry_select_adder_20bit` instance, unchanged.

## Test plan
- **Basic add:** requester 2 only, a=0x00005, b=0x00003, add, `rsp_ready`=1 → two cycles later `rsp_id`=2, `rsp_sum`=0x00008, `rsp_cout`=0, `rsp_v`=0.
- **Subtract and overflow:**
  - 0x00005−0x00003 → sum=0x00002, cout=1, v=0.
  - 0x7FFFF+0x00001 → v=1; sum=0x80000 without `ADDER_SAT_EN`, 0x7FFFF with it.
- **Round-robin:** all four requesters valid continuously from reset → grant order 0,1,2,3,0,1. `rsp_id` follows the same order one result per cycle, with no gaps.
- **Backpressure:** `rsp_ready`=0 for 5 cycles with all requesters valid → exactly 2 ops accepted and `req_ready`=0 thereafter. On release, results drain in order with none lost or duplicated.
- **Reset mid-operation:** assert `rst` while both stages are full → the next cycle `rsp_valid`=0. The first grant after reset goes to requester 0.
- **Skip idle requesters:** only requesters 1 and 3 valid → grants alternate 1,3,1,3; requesters 0 and 2 never see `req_ready`.

Source files
------------

// File: rtl/ode_pkg.sv
// Shared constants and types for the ODE solver datapath arbiters.
package ode_pkg;

  localparam int DATA_W   = 20;
  localparam int ID_MAX_W = 3;

  localparam logic ADD_OP = 1'b0;
  localparam logic SUB_OP = 1'b1;

  localparam logic [DATA_W-1:0] SAT_MAX = 20'h7FFFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 20'h80000;

  typedef struct packed {
    logic [DATA_W-1:0]   sum;
    logic                cout;
    logic                v;
    logic [ID_MAX_W-1:0] id;
  } s2_rec_t;

  // Encoding: bit0 = S1 full, bit1 = S2 full.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FILL  = 2'b01,
    ST_FULL  = 2'b11,
    ST_DRAIN = 2'b10
  } pipe_state_t;

  // An overflowed sum has the opposite sign of operand A, so the clamp
  // direction can be recovered from the wrapped sum alone.
  function automatic logic [DATA_W-1:0] sat_value(input logic [DATA_W-1:0] raw_sum);
    return raw_sum[DATA_W-1] ? SAT_MAX : SAT_MIN;
  endfunction

endpackage

// File: rtl/carry_select_adder_20bit.sv
// 20-bit carry-select adder/subtractor built from 4-bit blocks.
module carry_select_adder_20bit (
  input  logic [19:0] in0,
  input  logic [19:0] in1,
  input  logic        sub,
  input  logic        cin,
  output logic [19:0] sum,
  output logic        cout
);

  localparam int BLK  = 4;
  localparam int NBLK = 5;

  logic [19:0]   w_b;
  logic [NBLK:0] w_c;

  assign w_b    = in1 ^ {20{sub}};
  assign w_c[0] = cin ^ sub;

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [BLK:0] w_s0;
    logic [BLK:0] w_s1;
    assign w_s0 = {1'b0, in0[g*BLK +: BLK]} + {1'b0, w_b[g*BLK +: BLK]};
    assign w_s1 = w_s0 + 5'd1;
    assign sum[g*BLK +: BLK] = w_c[g] ? w_s1[BLK-1:0] : w_s0[BLK-1:0];
    assign w_c[g+1]          = w_c[g] ? w_s1[BLK]     : w_s0[BLK];
  end

  assign cout = w_c[NBLK];

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid requester after `last`, with wrap.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  last,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  logic [IDW-1:0] w_idx;
  logic           w_found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    w_idx    = '0;
    w_found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((int'(last) + k) % NREQ);
      if (enable && !w_found && req_valid[w_idx]) begin
        w_found         = 1'b1;
        grant[w_idx]    = 1'b1;
        grant_id        = w_idx;
      end
    end
  end

endmodule

// File: rtl/shared_adder_arbiter.sv
// Round-robin arbiter time-sharing one 20-bit adder across NREQ requesters.
// Build option ADDER_SAT_EN: clamp rsp_sum on signed overflow.
module shared_adder_arbiter
  import ode_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_sub,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [DATA_W-1:0]      rsp_sum,
  output logic                   rsp_cout,
  output logic                   rsp_v
);

  // state    | meaning
  // EMPTY    | no operation in flight
  // FILL     | operands in S1, S2 empty
  // FULL     | operands in S1, result in S2
  // DRAIN    | result in S2, S1 empty
  pipe_state_t r_state, w_state_nxt;

  logic              w_s1_full, w_s2_full, w_s2_adv, w_s1_free, w_pick_en, w_fire;
  logic [NREQ-1:0]   w_grant;
  logic [IDW-1:0]    w_grant_id, r_last;

  logic [DATA_W-1:0] r_s1_a, r_s1_b, w_sel_a, w_sel_b;
  logic              r_s1_sub, w_sel_sub;
  logic [IDW-1:0]    r_s1_id;

  s2_rec_t           r_s2;
  logic [DATA_W-1:0] w_add_sum;
  logic              w_add_cout, w_add_v, w_b_eff_msb;

  assign w_s1_full = (r_state == ST_FILL) || (r_state == ST_FULL);
  assign w_s2_full = (r_state == ST_FULL) || (r_state == ST_DRAIN);
  assign w_s2_adv  = w_s1_full && (!w_s2_full || rsp_ready);
  assign w_s1_free = !w_s1_full || w_s2_adv;
  assign w_pick_en = w_s1_free && !rst;
  assign w_fire    = |w_grant;

  rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
    .req_valid (req_valid),
    .last      (r_last),
    .enable    (w_pick_en),
    .grant     (w_grant),
    .grant_id  (w_grant_id)
  );

  assign req_ready = w_grant;

  always_comb begin
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_sub = ADD_OP;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a   = req_a[i*DATA_W +: DATA_W];
        w_sel_b   = req_b[i*DATA_W +: DATA_W];
        w_sel_sub = req_sub[i];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: w_state_nxt = w_fire ? ST_FILL : ST_EMPTY;
      ST_FILL:  w_state_nxt = w_fire ? ST_FULL : ST_DRAIN;
      ST_FULL: begin
        if (rsp_ready) w_state_nxt = w_fire ? ST_FULL : ST_DRAIN;
        else           w_state_nxt = ST_FULL;
      end
      ST_DRAIN: begin
        case ({!rsp_ready, w_fire})
          2'b11:   w_state_nxt = ST_FULL;
          2'b10:   w_state_nxt = ST_DRAIN;
          2'b01:   w_state_nxt = ST_FILL;
          default: w_state_nxt = ST_EMPTY;
        endcase
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  carry_select_adder_20bit u_adder (
    .in0  (r_s1_a),
    .in1  (r_s1_b),
    .sub  (r_s1_sub),
    .cin  (1'b0),
    .sum  (w_add_sum),
    .cout (w_add_cout)
  );

  assign w_b_eff_msb = r_s1_b[DATA_W-1] ^ r_s1_sub;
  assign w_add_v     = (r_s1_a[DATA_W-1] == w_b_eff_msb) &&
                       (w_add_sum[DATA_W-1] != r_s1_a[DATA_W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_EMPTY;
      r_last   <= IDW'(NREQ - 1);
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_sub <= 1'b0;
      r_s1_id  <= '0;
      r_s2     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) begin
        r_last   <= w_grant_id;
        r_s1_a   <= w_sel_a;
        r_s1_b   <= w_sel_b;
        r_s1_sub <= w_sel_sub;
        r_s1_id  <= w_grant_id;
      end
      if (w_s2_adv) begin
        r_s2.sum  <= w_add_sum;
        r_s2.cout <= w_add_cout;
        r_s2.v    <= w_add_v;
        r_s2.id   <= ID_MAX_W'(r_s1_id);
      end
    end
  end

  assign rsp_valid = w_s2_full;
  assign rsp_id    = IDW'(r_s2.id);
  assign rsp_cout  = r_s2.cout;
  assign rsp_v     = r_s2.v;

`ifdef ADDER_SAT_EN
  assign rsp_sum = r_s2.v ? sat_value(r_s2.sum) : r_s2.sum;
`else
  assign rsp_sum = r_s2.sum;
`endif

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Self-checking bench for shared_adder_arbiter: vector table plus scoreboard.
module tb_shared_adder_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int DW   = 20;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_sub;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_sum;
  logic               rsp_cout;
  logic               rsp_v;

  shared_adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sub   (req_sub),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_v     (rsp_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  sum;
    logic           cout;
    logic           v;
  } exp_t;

  typedef struct {
    int            id;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          sub;
    logic [DW-1:0] exp_sum;
    logic          exp_cout;
    logic          exp_v;
  } vec_t;

  exp_t            sb_q[$];
  int              grant_log[$];
  int              grant_cyc_log[$];
  int              rsp_id_log[$];
  int              rsp_cyc_log[$];
  vec_t            vecs[10];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  int              hs_total = 0;
  int              rsp_total = 0;
  bit              auto_push = 1'b1;
  bit              auto_refresh = 1'b1;
  bit              seen_ready02 = 1'b0;
  logic [NREQ-1:0] hs_mask = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic sub);
    exp_t        e;
    logic [20:0] full;
    int          sa, sb, r;
    full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + 21'(sub);
    sa   = $signed(a);
    sb   = $signed(b);
    r    = sub ? (sa - sb) : (sa + sb);
    e.id   = IDW'(id);
    e.cout = full[20];
    e.v    = (r > 524287) || (r < -524288);
    e.sum  = full[19:0];
`ifdef ADDER_SAT_EN
    if (e.v) e.sum = (r > 0) ? 20'h7FFFF : 20'h80000;
`endif
    return e;
  endfunction

  task automatic rand_op(input int i);
    req_a[i*DW +: DW] = 20'($urandom);
    req_b[i*DW +: DW] = 20'($urandom);
    req_sub[i]        = 1'($urandom);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || rsp_valid) && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    check("drain_empty", sb_q.size(), 0);
  endtask

  // Monitor: records handshakes, feeds and drains the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        sb_q.delete();
        hs_mask = '0;
      end else begin
        hs_mask = req_valid & req_ready;
        if (req_ready[0] || req_ready[2]) seen_ready02 = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
          if (hs_mask[i]) begin
            hs_total++;
            grant_log.push_back(i);
            grant_cyc_log.push_back(cyc);
            if (auto_push) sb_q.push_back(model(i, req_a[i*DW +: DW], req_b[i*DW +: DW], req_sub[i]));
          end
        end
        if (rsp_valid && rsp_ready) begin
          rsp_total++;
          rsp_id_log.push_back(int'(rsp_id));
          rsp_cyc_log.push_back(cyc);
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got id %0d sum %0h with no pending op (cycle %0d)",
                     rsp_id, rsp_sum, cyc);
          end else begin
            e = sb_q.pop_front();
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
            check("rsp_cout", 32'(rsp_cout), 32'(e.cout));
            check("rsp_v", 32'(rsp_v), 32'(e.v));
          end
        end
      end
    end
  end

  // Continuously-valid requesters get fresh operands after each handshake.
  initial begin : refresher
    forever begin
      @(posedge clk); #1;
      if (auto_refresh) begin
        for (int i = 0; i < NREQ; i++) if (hs_mask[i]) rand_op(i);
      end
    end
  end

  initial begin : watchdog
    #100000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int rr_exp[6];
    int skip_exp[4];
    int h0, r0, t;
    bit got;

    rr_exp   = '{0, 1, 2, 3, 0, 1};
    skip_exp = '{1, 3, 1, 3};

    vecs[0] = '{2, 20'h00005, 20'h00003, 1'b0, 20'h00008, 1'b0, 1'b0};
    vecs[1] = '{0, 20'h00005, 20'h00003, 1'b1, 20'h00002, 1'b1, 1'b0};
    vecs[4] = '{0, 20'hFFFFF, 20'h00001, 1'b0, 20'h00000, 1'b1, 1'b0};
    vecs[5] = '{1, 20'h00003, 20'h00005, 1'b1, 20'hFFFFE, 1'b0, 1'b0};
    vecs[6] = '{2, 20'h00000, 20'h00000, 1'b1, 20'h00000, 1'b1, 1'b0};
    vecs[8] = '{0, 20'h12345, 20'h0ABCD, 1'b0, 20'h1CF12, 1'b0, 1'b0};
`ifdef ADDER_SAT_EN
    vecs[2] = '{1, 20'h7FFFF, 20'h00001, 1'b0, 20'h7FFFF, 1'b0, 1'b1};
    vecs[3] = '{3, 20'h80000, 20'h00001, 1'b1, 20'h80000, 1'b1, 1'b1};
    vecs[7] = '{3, 20'h80000, 20'h80000, 1'b0, 20'h80000, 1'b1, 1'b1};
    vecs[9] = '{3, 20'h40000, 20'h40000, 1'b0, 20'h7FFFF, 1'b0, 1'b1};
`else
    vecs[2] = '{1, 20'h7FFFF, 20'h00001, 1'b0, 20'h80000, 1'b0, 1'b1};
    vecs[3] = '{3, 20'h80000, 20'h00001, 1'b1, 20'h7FFFF, 1'b1, 1'b1};
    vecs[7] = '{3, 20'h80000, 20'h80000, 1'b0, 20'h00000, 1'b1, 1'b1};
    vecs[9] = '{3, 20'h40000, 20'h40000, 1'b0, 20'h80000, 1'b0, 1'b1};
`endif

    rst       = 1'b1;
    req_valid = '0;
    req_sub   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) rand_op(i);

    // Reset values, with every requester asking during the reset cycle.
    tick(1);
    req_valid = '1;
    @(negedge clk); #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_sum", 32'(rsp_sum), 0);
    check("rst_rsp_cout", 32'(rsp_cout), 0);
    check("rst_rsp_v", 32'(rsp_v), 0);
    check("rst_req_ready", 32'(req_ready), 0);

    // Round-robin from reset, all requesters continuously valid.
    @(posedge clk); #1;
    rst = 1'b0;
    grant_log.delete(); grant_cyc_log.delete(); rsp_id_log.delete(); rsp_cyc_log.delete();
    t = 0;
    while (rsp_id_log.size() < 6 && t < 30) begin
      @(negedge clk); #1;
      t++;
    end
    check("rr_rsp_count", 32'(rsp_id_log.size() >= 6), 1);
    if (rsp_id_log.size() >= 6 && grant_log.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        check($sformatf("rr_grant_%0d", k), 32'(grant_log[k]), 32'(rr_exp[k]));
        check($sformatf("rr_rsp_id_%0d", k), 32'(rsp_id_log[k]), 32'(rr_exp[k]));
        if (k > 0) check($sformatf("rr_rsp_gap_%0d", k), 32'(rsp_cyc_log[k] - rsp_cyc_log[k-1]), 1);
      end
      check("rr_latency", 32'(rsp_cyc_log[0] - grant_cyc_log[0]), 2);
    end

    // Backpressure from an empty pipeline.
    @(posedge clk); #1;
    req_valid = '0;
    drain();
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = '1;
    h0 = hs_total;
    r0 = rsp_total;
    repeat (5) @(negedge clk);
    #1;
    check("bp_accepted", 32'(hs_total - h0), 2);
    check("bp_ready_low", 32'(req_ready), 0);
    check("bp_rsp_held", 32'(rsp_valid), 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    tick(4);
    req_valid = '0;
    drain();
    check("bp_no_loss", 32'(rsp_total - r0), 32'(hs_total - h0));

    // Reset with both stages full.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = '1;
    tick(3);
    check("pre_rst_full", 32'(rsp_valid), 1);
    rst = 1'b1;
    @(negedge clk); #1;
    check("midrst_req_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 0);
    check("midrst_first_grant", 32'(req_ready), 32'h1);

    // Only requesters 1 and 3 valid.
    @(posedge clk); #1;
    rsp_ready    = 1'b1;
    req_valid    = 4'b1010;
    grant_log.delete();
    seen_ready02 = 1'b0;
    t = 0;
    while (grant_log.size() < 4 && t < 20) begin
      @(negedge clk); #1;
      t++;
    end
    check("skip_count", 32'(grant_log.size() >= 4), 1);
    if (grant_log.size() >= 4)
      for (int k = 0; k < 4; k++) check($sformatf("skip_grant_%0d", k), 32'(grant_log[k]), 32'(skip_exp[k]));
    check("skip_idle_ready", 32'(seen_ready02), 0);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Directed vector table, one op at a time with latency checks.
    @(posedge clk); #1;
    auto_push    = 1'b0;
    auto_refresh = 1'b0;
    for (int k = 0; k < 10; k++) begin
      req_a[vecs[k].id*DW +: DW] = vecs[k].a;
      req_b[vecs[k].id*DW +: DW] = vecs[k].b;
      req_sub[vecs[k].id]        = vecs[k].sub;
      req_valid                  = NREQ'(1) << vecs[k].id;
      got = 1'b0;
      t   = 0;
      while (!got && t < 20) begin
        @(negedge clk); #1;
        t++;
        if ((req_valid & req_ready) != '0) got = 1'b1;
      end
      check($sformatf("vec%0d_handshake", k), 32'(got), 1);
      if (got) sb_q.push_back('{IDW'(vecs[k].id), vecs[k].exp_sum, vecs[k].exp_cout, vecs[k].exp_v});
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk); #1;
      check($sformatf("vec%0d_lat1", k), 32'(rsp_valid), 0);
      @(negedge clk); #1;
      check($sformatf("vec%0d_lat2", k), 32'(rsp_valid), 1);
      @(posedge clk); #1;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
